// File: rtl/ez8_pkg.sv
// Shared ez8 execute-stage definitions: sequencer state encoding, STATUS bit positions, opcode width.
package ez8_pkg;
    localparam int OPCODE_W = 4;

    localparam int STAT_Z   = 0;
    localparam int STAT_C   = 1;
    localparam int STAT_GIE = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4
    } seq_state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// Decoded-instruction handshake into the execute stage; the decoder is master, the sequencer is slave.
interface alu_sequencer_if
    import ez8_pkg::*;
#(
    parameter int ADDR_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] in_opcode;
    logic [7:0]          in_operand;
    logic [2:0]          in_selector;
    logic                in_direction;
    logic [ADDR_W-1:0]   in_addr;

    modport master (output in_valid, in_opcode, in_operand, in_selector, in_direction, in_addr,
                    input  in_ready);
    modport slave  (input  in_valid, in_opcode, in_operand, in_selector, in_direction, in_addr,
                    output in_ready);
endinterface

// File: rtl/alu_sequencer_rf_read_timer.sv
// Counts register-file read latency from the read strobe; done is high in the cycle rf_rdata is valid.
// RD_LAT cycles after start; no backpressure, a new start restarts the count.
module rf_read_timer #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic done
);
    localparam logic [1:0] LAT = 2'(RD_LAT);

    logic [1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 2'd0;
        end else if (start) begin
            cnt <= 2'd1;
        end else if (cnt != 2'd0 && cnt != LAT) begin
            cnt <= cnt + 2'd1;
        end else begin
            cnt <= 2'd0;
        end
    end

    assign done = (cnt == LAT);
endmodule

// File: rtl/alu_sequencer.sv
// ez8 execute-stage controller: operand fetch, ALU drive, accumulator/STATUS ownership, write-back, skip and irq entry.
// Accept-to-ready 2+RD_LAT cycles (more with write-back); one instruction in flight, in_ready low while busy.
module alu_sequencer
    import ez8_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_sequencer_if.slave      ib,
    output logic [ADDR_W-1:0]   rf_raddr,
    input  logic [7:0]          rf_rdata,
    output logic                rf_re,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [7:0]          rf_wdata,
    output logic                rf_we,
    input  logic                rf_wack,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic [7:0]          alu_operand,
    output logic [2:0]          alu_selector,
    output logic                alu_direction,
    output logic [7:0]          alu_regvalue,
    output logic [7:0]          alu_accum,
    output logic                alu_cin,
    input  logic [7:0]          alu_result,
    input  logic                alu_accum_write,
    input  logic                alu_reg_write,
    input  logic                alu_z_write,
    input  logic                alu_zout,
    input  logic                alu_c_write,
    input  logic                alu_cout,
    input  logic                alu_gie_write,
    input  logic                alu_gieout,
    input  logic                alu_skip,
    input  logic                irq,
    output logic                irq_take,
    output logic [7:0]          accum,
    output logic [2:0]          status,
    output logic                busy
);
    seq_state_t state_q, state_d;

    logic [OPCODE_W-1:0] op_q;
    logic [7:0]          operand_q, regval_q, accum_q, wdata_q;
    logic [2:0]          sel_q, flags_q;
    logic                dir_q, skip_q, alive_q, rd_done, ready, accept;
    logic [ADDR_W-1:0]   addr_q, waddr_q;

    rf_read_timer #(.RD_LAT(RD_LAT)) u_rd_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (rf_re),
        .done    (rd_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && !skip_q) state_d = ST_READ;
            ST_READ:  state_d = rd_done ? ST_EXEC : ST_WAIT;
            ST_WAIT:  if (rd_done) state_d = ST_EXEC;
            ST_EXEC:  state_d = alu_reg_write ? ST_WRITE : ST_IDLE;
            ST_WRITE: if (rf_wack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // alive_q keeps in_ready low while reset is asserted and for the first cycle after release
    always_comb begin
        ready    = 1'b0;
        irq_take = 1'b0;
        rf_re    = 1'b0;
        rf_raddr = addr_q;
        if (state_q == ST_IDLE) begin
            irq_take = irq && flags_q[STAT_GIE];
            ready    = alive_q && !irq_take;
            rf_raddr = ib.in_addr;
            rf_re    = ib.in_valid && ready && !skip_q;
        end
        rf_we = (state_q == ST_WRITE);
        busy  = (state_q != ST_IDLE);
    end

    assign ib.in_ready = ready;
    assign accept      = ib.in_valid && ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive_q   <= 1'b0;
            op_q      <= '0;
            operand_q <= '0;
            sel_q     <= '0;
            dir_q     <= 1'b0;
            addr_q    <= '0;
            regval_q  <= '0;
            accum_q   <= '0;
            flags_q   <= '0;
            skip_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            alive_q <= 1'b1;
            if (irq_take) flags_q[STAT_GIE] <= 1'b0;
            if (accept) begin
                if (skip_q) begin
                    skip_q <= 1'b0;
                end else begin
                    op_q      <= ib.in_opcode;
                    operand_q <= ib.in_operand;
                    sel_q     <= ib.in_selector;
                    dir_q     <= ib.in_direction;
                    addr_q    <= ib.in_addr;
                end
            end
            if ((state_q == ST_READ || state_q == ST_WAIT) && rd_done) regval_q <= rf_rdata;
            if (state_q == ST_EXEC) begin
                if (alu_z_write)     flags_q[STAT_Z]   <= alu_zout;
                if (alu_c_write)     flags_q[STAT_C]   <= alu_cout;
                if (alu_gie_write)   flags_q[STAT_GIE] <= alu_gieout;
                if (alu_accum_write) accum_q           <= alu_result;
                skip_q <= alu_skip;
                if (alu_reg_write) begin
                    wdata_q <= alu_result;
                    waddr_q <= addr_q;
                end
            end
        end
    end

    assign rf_waddr      = waddr_q;
    assign rf_wdata      = wdata_q;
    assign alu_opcode    = op_q;
    assign alu_operand   = operand_q;
    assign alu_selector  = sel_q;
    assign alu_direction = dir_q;
    assign alu_regvalue  = regval_q;
    assign alu_accum     = accum_q;
    assign alu_cin       = flags_q[STAT_C];
    assign accum         = accum_q;
    assign status        = flags_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Random instruction stream against an architectural model; a negedge monitor checks reads, writes, irq entry and per-instruction state.
module tb_alu_sequencer;
    localparam int ADDR_W = 5;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_sequencer_if #(.ADDR_W(ADDR_W)) ib ();

    logic [ADDR_W-1:0] rf_raddr, rf_waddr;
    logic [7:0]        rf_rdata, rf_wdata;
    logic              rf_re, rf_we, rf_wack;
    logic [3:0]        alu_opcode;
    logic [7:0]        alu_operand, alu_regvalue, alu_accum, alu_result, accum;
    logic [2:0]        alu_selector, status;
    logic              alu_direction, alu_cin, irq, irq_take, busy;
    logic              alu_accum_write, alu_reg_write, alu_z_write, alu_zout, alu_c_write;
    logic              alu_cout, alu_gie_write, alu_gieout, alu_skip;

    typedef struct packed {
        logic [7:0] result;
        logic accum_write, reg_write, z_write, zout, c_write, cout, gie_write, gieout, skip;
    } alu_o_t;

    typedef struct {
        logic [7:0] acc;
        logic [2:0] st;
        bit         wr;
    } exp_st_t;

    // Reference ALU: ops 0-5 arithmetic/logic/move, 6 GIE set/clear, 7 bit-test skip; op[0] picks register source.
    function automatic alu_o_t alu_fn(input logic [3:0] op, input logic [7:0] imm, input logic [2:0] sel,
                                      input logic dir, input logic [7:0] rv, input logic [7:0] acc, input logic cin);
        alu_o_t     o;
        logic [8:0] w;
        logic [7:0] src;
        o   = '0;
        src = op[0] ? rv : imm;
        case (op[3:1])
            3'd0:    w = {1'b0, acc} + {1'b0, src};
            3'd1:    w = {1'b0, acc} - {1'b0, src};
            3'd2:    w = {1'b0, acc & src};
            3'd3:    w = {1'b0, acc ^ src};
            3'd4:    w = {1'b0, acc} + {1'b0, src} + 9'(cin);
            3'd5:    w = {1'b0, src};
            default: w = '0;
        endcase
        if (op[3:1] <= 3'd5) begin
            o.result      = w[7:0];
            o.z_write     = 1'b1;
            o.zout        = (w[7:0] == 8'd0);
            o.c_write     = (op[3:1] inside {3'd0, 3'd1, 3'd4});
            o.cout        = w[8];
            o.accum_write = !dir;
            o.reg_write   = dir;
            o.skip        = (op[3:1] == 3'd5) && sel[0] && (w[7:0] == 8'd0);
        end else if (op[3:1] == 3'd6) begin
            o.gie_write = 1'b1;
            o.gieout    = sel[0];
        end else begin
            o.skip = src[sel];
        end
        return o;
    endfunction

    alu_o_t alu_o;
    always_comb alu_o = alu_fn(alu_opcode, alu_operand, alu_selector, alu_direction, alu_regvalue, alu_accum, alu_cin);
    assign alu_result      = alu_o.result;
    assign alu_accum_write = alu_o.accum_write;
    assign alu_reg_write   = alu_o.reg_write;
    assign alu_z_write     = alu_o.z_write;
    assign alu_zout        = alu_o.zout;
    assign alu_c_write     = alu_o.c_write;
    assign alu_cout        = alu_o.cout;
    assign alu_gie_write   = alu_o.gie_write;
    assign alu_gieout      = alu_o.gieout;
    assign alu_skip        = alu_o.skip;

    alu_sequencer #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .ib(ib),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_re(rf_re),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_wack(rf_wack),
        .alu_opcode(alu_opcode), .alu_operand(alu_operand), .alu_selector(alu_selector),
        .alu_direction(alu_direction), .alu_regvalue(alu_regvalue), .alu_accum(alu_accum), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_accum_write(alu_accum_write), .alu_reg_write(alu_reg_write),
        .alu_z_write(alu_z_write), .alu_zout(alu_zout), .alu_c_write(alu_c_write), .alu_cout(alu_cout),
        .alu_gie_write(alu_gie_write), .alu_gieout(alu_gieout), .alu_skip(alu_skip),
        .irq(irq), .irq_take(irq_take), .accum(accum), .status(status), .busy(busy)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    task automatic fail_evt(input string nm);
        total++;
        $display("FAIL %s: got an unexpected event, required none", nm);
    endtask

    // Architectural model state and the environment register file
    logic [7:0] m_acc;
    logic       m_z, m_c, m_gie, m_skip;
    logic [7:0] m_mem [32];
    logic [7:0] e_mem [32];

    exp_st_t           q_st[$];
    logic [ADDR_W-1:0] q_rd[$];
    logic [12:0]       q_wr[$];
    bit                q_irq[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                rd_at = -1;
    logic [ADDR_W-1:0] rd_addr;
    int                acc_cyc = 0;
    int                wdly = 0;
    bit                we_open = 0, env_open = 0, prev_busy = 0, wack_hold = 0;
    logic [12:0]       held;

    always @(negedge clk) begin
        if (!reset_n) begin
            we_open = 0; env_open = 0; prev_busy = 0; rd_at = -1; rf_wack = 1'b0;
        end else begin
            if (rf_we && !wack_hold) begin
                if (!env_open) wdly = $urandom_range(0, 3);
                rf_wack = (wdly == 0);
                if (wdly > 0) wdly--;
            end else if (rf_we) begin
                rf_wack = 1'b0;
            end else begin
                rf_wack = ($urandom_range(0, 3) == 0);
            end
            env_open = rf_we && !rf_wack;

            if (rf_re) begin
                if (q_rd.size() == 0) fail_evt("rf_re_spurious");
                else chk("rf_raddr", rf_raddr, q_rd.pop_front());
                acc_cyc = cyc;
                rd_at   = cyc + RD_LAT;
                rd_addr = rf_raddr;
            end
            if (rf_we) begin
                if (we_open) chk("wr_hold_stable", {rf_waddr, rf_wdata}, held);
                held = {rf_waddr, rf_wdata};
                if (rf_wack) begin
                    if (q_wr.size() == 0) fail_evt("rf_write_spurious");
                    else chk("rf_write", {rf_waddr, rf_wdata}, q_wr.pop_front());
                    e_mem[rf_waddr] = rf_wdata;
                    we_open = 0;
                end else begin
                    we_open = 1;
                end
            end
            if (irq_take) begin
                chk("in_ready_at_take", ib.in_ready, 0);
                if (q_irq.size() == 0) fail_evt("irq_take_spurious");
                else void'(q_irq.pop_front());
            end
            if (prev_busy && !busy) begin
                if (q_st.size() == 0) fail_evt("completion_spurious");
                else begin
                    exp_st_t e;
                    e = q_st.pop_front();
                    chk("accum", accum, e.acc);
                    chk("status", status, e.st);
                    if (e.wr) chk("wr_latency_min", (cyc - acc_cyc) >= 3 + RD_LAT, 1);
                    else      chk("latency", cyc - acc_cyc, 2 + RD_LAT);
                end
            end
            prev_busy = busy;
            // register data only in the exact latency cycle; junk otherwise exposes mistimed capture
            rf_rdata = (cyc == rd_at) ? e_mem[rd_addr] : 8'($urandom);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] imm, input logic [2:0] sel, input logic dir,
                         input logic [ADDR_W-1:0] addr, input bit use_irq, input bit wait_done);
        alu_o_t a;
        int     n;
        bit     got;
        if (m_skip) begin
            m_skip = 0;
        end else begin
            q_rd.push_back(addr);
            a = alu_fn(op, imm, sel, dir, m_mem[addr], m_acc, m_c);
            if (a.z_write)     m_z   = a.zout;
            if (a.c_write)     m_c   = a.cout;
            if (a.gie_write)   m_gie = a.gieout;
            if (a.accum_write) m_acc = a.result;
            m_skip = a.skip;
            if (a.reg_write) begin
                m_mem[addr] = a.result;
                q_wr.push_back({addr, a.result});
            end
            q_st.push_back('{acc: m_acc, st: {m_gie, m_c, m_z}, wr: a.reg_write});
        end
        if (use_irq && m_gie) begin
            m_gie = 0;
            q_irq.push_back(1'b1);
        end

        ib.in_valid = 1'b1; ib.in_opcode = op; ib.in_operand = imm;
        ib.in_selector = sel; ib.in_direction = dir; ib.in_addr = addr;
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk); got = ib.in_ready;
            @(posedge clk); #2; n++;
        end
        ib.in_valid = 1'b0;
        if (!got) fail_evt("accept_timeout");
        if (!wait_done) return;
        if (use_irq) irq = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) fail_evt("busy_timeout");
        @(posedge clk); #2;
        irq = 1'b0;
    endtask

    task automatic run_random(input int count);
        for (int i = 0; i < count; i++)
            issue(4'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 5'($urandom),
                  $urandom_range(0, 3) == 0, 1);
    endtask

    initial begin
        logic [7:0] saved;
        int         n;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 8'($urandom);
            e_mem[i] = m_mem[i];
        end
        m_acc = 0; m_z = 0; m_c = 0; m_gie = 0; m_skip = 0;
        ib.in_valid = 0; ib.in_opcode = 0; ib.in_operand = 0; ib.in_selector = 0;
        ib.in_direction = 0; ib.in_addr = 0; irq = 0; rf_rdata = 0; rf_wack = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_in_ready", ib.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rf_re", rf_re, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_irq_take", irq_take, 0);
        chk("rst_accum", accum, 0);
        chk("rst_status", status, 0);
        chk("rst_alu_fields", {alu_opcode, alu_operand, alu_selector, alu_direction, alu_regvalue}, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #2;

        run_random(150);

        if (m_skip) issue(4'd0, 8'h11, 3'd0, 1'b0, 5'd0, 0, 1);
        wack_hold = 1;
        saved = m_mem[5'd9];
        issue(4'd0, 8'h5A, 3'd0, 1'b1, 5'd9, 0, 0);
        n = 0;
        while (!rf_we && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_evt("write_start_timeout");
        #2 reset_n = 1'b0;
        #1;
        chk("midwr_rst_rf_we", rf_we, 0);
        chk("midwr_rst_busy", busy, 0);
        chk("midwr_rst_accum", accum, 0);
        chk("midwr_rst_status", status, 0);
        m_acc = 0; m_z = 0; m_c = 0; m_gie = 0; m_skip = 0;
        m_mem[5'd9] = saved;
        q_st.delete(); q_wr.delete(); q_rd.delete(); q_irq.delete();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        wack_hold = 0;

        run_random(40);

        repeat (3) @(posedge clk);
        #2;
        chk("final_accum", accum, m_acc);
        chk("final_status", status, {m_gie, m_c, m_z});
        chk("pending_states", q_st.size(), 0);
        chk("pending_reads", q_rd.size(), 0);
        chk("pending_writes", q_wr.size(), 0);
        chk("pending_irqs", q_irq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
